mem_stage_sram_ctrl: RTL

Memory-stage data-memory controller of the 32-bit ARM pipeline. It sits directly downstream of the EXE/MEM pipeline register: it consumes the registered ALU result (the address), the Rm value (the store data) and the memory read/write enables, and performs the access on an external 16-bit asynchronous SRAM as two half-word transfers. It returns the loaded word to the MEM/WB register and asserts `freeze` to stall the whole pipeline until the access completes.

---
 rtl/mem_stage_sram_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// Data-memory controller for the MEM stage: splits each 32-bit load/store into
// two half-word transfers on a 16-bit asynchronous SRAM and stalls the pipeline meanwhile.
module mem_stage_sram_ctrl #(
  parameter int WORD_WIDTH    = 32,
  parameter int SRAM_ADDR_W   = 18,
  parameter int SRAM_DATA_W   = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int BASE_ADDR     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [WORD_WIDTH-1:0]  addr,
  input  logic [WORD_WIDTH-1:0]  wdata,
  output logic [WORD_WIDTH-1:0]  rdata,
  output logic                   freeze,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int IDX_W = SRAM_ADDR_W - 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  write_reg, write_next;
  logic [WORD_WIDTH-1:0] rdata_reg;

  logic                  req;
  logic                  last_cnt;
  logic [WORD_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      word_idx;
  logic                  unused_addr_bits;

  assign req      = mem_r_en | mem_w_en;
  assign last_cnt = (cnt_reg == CNT_W'(ACCESS_CYCLES - 1));
  // Subtraction wraps naturally; the byte offset within a word is discarded.
  assign offset   = addr - WORD_WIDTH'(BASE_ADDR);
  assign word_idx = offset[IDX_W+1:2];
  assign unused_addr_bits = ^{offset[1:0], offset[WORD_WIDTH-1:IDX_W+2]};
  assign rdata    = rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      write_reg <= write_next;
    end
  end

  // Load halves are captured on the final cycle of each transfer window.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (!write_reg && last_cnt) begin
      if (state_reg == LO)
        rdata_reg[SRAM_DATA_W-1:0] <= sram_dq_in;
      else if (state_reg == HI)
        rdata_reg[WORD_WIDTH-1:SRAM_DATA_W] <= sram_dq_in;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    write_next = write_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = LO;
          cnt_next   = '0;
          write_next = mem_w_en;
        end
      end
      LO: begin
        if (last_cnt) begin
          state_next = HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HI: begin
        if (last_cnt) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    freeze      = req && (state_reg != DONE);
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_reg)
      LO: begin
        sram_addr = {word_idx, 1'b0};
        if (write_reg) begin
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
          sram_dq_out = wdata[SRAM_DATA_W-1:0];
        end
      end
      HI: begin
        sram_addr = {word_idx, 1'b1};
        if (write_reg) begin
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
          sram_dq_out = wdata[WORD_WIDTH-1:SRAM_DATA_W];
        end
      end
      default: ;
    endcase
  end

endmodule
